// File: rtl/stage_mem_if.sv
// EX -> MEM -> WB signal bundle plus the data-memory request/acknowledge bus.
// No logic here; timing is set by stage_mem.
// Backpressure is carried by in_ready toward EX.
interface stage_mem_if #(
    parameter int ADDR_W = 30
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       ans_ex;
    logic [4:0]        rw_ex;
    logic [31:0]       b_ex;
    logic              wreg_ex;
    logic              m2reg_ex;
    logic              wmem_ex;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    logic              wb_valid;
    logic              wb_wreg;
    logic [4:0]        wb_rw;
    logic [31:0]       wb_data;
    logic              misalign_err;

    // stage_mem side
    modport slave (
        input  in_valid, ans_ex, rw_ex, b_ex, wreg_ex, m2reg_ex, wmem_ex,
        input  mem_rdata, mem_ack,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output wb_valid, wb_wreg, wb_rw, wb_data, misalign_err
    );

    // EX / memory / WB side
    modport master (
        output in_valid, ans_ex, rw_ex, b_ex, wreg_ex, m2reg_ex, wmem_ex,
        output mem_rdata, mem_ack,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  wb_valid, wb_wreg, wb_rw, wb_data, misalign_err
    );
endinterface

// File: rtl/stage_mem.sv
// MIPS MEM stage: registers EX results and runs word loads/stores on a req/ack bus.
// Latency: ALU ops 1 cycle; memory ops accept + bus latency + 1.
// Backpressure: in_ready is low while a bus access is outstanding.
module stage_mem #(
    parameter int ADDR_W = 30
) (
    input  logic        clk,
    input  logic        rst,
    stage_mem_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_n;

    logic       cap_store;
    logic       cap_wreg;
    logic [4:0] cap_rw;

    logic accept;
    logic is_mem;
    logic misaligned;
    logic mem_go;

    assign bus.in_ready = (state == IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mem       = bus.m2reg_ex || bus.wmem_ex;
    assign misaligned   = (bus.ans_ex[1:0] != 2'b00);
    assign mem_go       = accept && is_mem && !misaligned;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (mem_go) state_n = BUSY;
            BUSY: if (bus.mem_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.wb_valid     <= 1'b0;
            bus.wb_wreg      <= 1'b0;
            bus.wb_rw        <= '0;
            bus.wb_data      <= '0;
            bus.misalign_err <= 1'b0;
            cap_store        <= 1'b0;
            cap_wreg         <= 1'b0;
            cap_rw           <= '0;
        end else begin
            bus.wb_valid     <= 1'b0;
            bus.wb_wreg      <= 1'b0;
            bus.misalign_err <= 1'b0;

            if (state == IDLE && accept) begin
                if (!is_mem) begin
                    bus.wb_valid <= 1'b1;
                    bus.wb_data  <= bus.ans_ex;
                    bus.wb_rw    <= bus.rw_ex;
                    bus.wb_wreg  <= bus.wreg_ex && (bus.rw_ex != 5'd0);
                end else if (misaligned) begin
                    bus.misalign_err <= 1'b1;
                    bus.wb_valid     <= 1'b1;
                    bus.wb_rw        <= bus.rw_ex;
                    bus.wb_data      <= '0;
                end else begin
                    // wmem dominates when both m2reg and wmem are set
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= bus.wmem_ex;
                    bus.mem_addr  <= bus.ans_ex[ADDR_W+1:2];
                    bus.mem_wdata <= bus.b_ex;
                    cap_store     <= bus.wmem_ex;
                    cap_wreg      <= bus.wreg_ex;
                    cap_rw        <= bus.rw_ex;
                end
            end else if (state == BUSY && bus.mem_ack) begin
                bus.mem_req  <= 1'b0;
                bus.wb_valid <= 1'b1;
                bus.wb_rw    <= cap_rw;
                if (cap_store) begin
                    bus.wb_data <= '0;
                end else begin
                    bus.wb_data <= bus.mem_rdata;
                    bus.wb_wreg <= cap_wreg && (cap_rw != 5'd0);
                end
            end
        end
    end
endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: ALU passthrough, loads/stores with variable ack latency,
// misalignment, rw=0, reset mid-access, spurious acks.
module tb_stage_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    stage_mem_if #(.ADDR_W(30)) bus ();

    stage_mem #(.ADDR_W(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ans, input logic [4:0] rw,
                          input logic [31:0] b, input logic wreg, input logic m2reg,
                          input logic wmem);
        bus.in_valid = v;
        bus.ans_ex   = ans;
        bus.rw_ex    = rw;
        bus.b_ex     = b;
        bus.wreg_ex  = wreg;
        bus.m2reg_ex = m2reg;
        bus.wmem_ex  = wmem;
    endtask

    initial begin
        set_in(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_misalign", {31'b0, bus.misalign_err}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_mem_addr", {2'b0, bus.mem_addr}, 32'd0);

        // ALU passthrough, three back-to-back
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h0000_1234 + i, 5'd5, 32'h0, 1'b1, 1'b0, 1'b0);
            step();
            chk("alu_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
            chk("alu_wb_data", bus.wb_data, 32'h0000_1234 + i);
            chk("alu_wb_rw", {27'b0, bus.wb_rw}, 32'd5);
            chk("alu_wb_wreg", {31'b0, bus.wb_wreg}, 32'd1);
            chk("alu_in_ready", {31'b0, bus.in_ready}, 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("alu_idle_valid", {31'b0, bus.wb_valid}, 32'd0);
        chk("alu_hold_data", bus.wb_data, 32'h0000_1236);

        // Load, ack on 3rd request cycle; second instruction waits
        set_in(1'b1, 32'h0000_0040, 5'd8, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        set_in(1'b1, 32'h0000_0077, 5'd9, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("ld_req", {31'b0, bus.mem_req}, 32'd1);
            chk("ld_addr", {2'b0, bus.mem_addr}, 32'h10);
            chk("ld_we", {31'b0, bus.mem_we}, 32'd0);
            chk("ld_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("ld_no_wb", {31'b0, bus.wb_valid}, 32'd0);
            if (c == 2) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        bus.mem_ack = 1'b0;
        chk("ld_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        chk("ld_wb_data", bus.wb_data, 32'hDEAD_BEEF);
        chk("ld_wb_rw", {27'b0, bus.wb_rw}, 32'd8);
        chk("ld_wb_wreg", {31'b0, bus.wb_wreg}, 32'd1);
        chk("ld_req_drop", {31'b0, bus.mem_req}, 32'd0);
        chk("ld_ready_back", {31'b0, bus.in_ready}, 32'd1);
        step();
        chk("held_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        chk("held_wb_data", bus.wb_data, 32'h0000_0077);
        chk("held_wb_rw", {27'b0, bus.wb_rw}, 32'd9);
        bus.in_valid = 1'b0;
        step();
        chk("held_no_dup", {31'b0, bus.wb_valid}, 32'd0);

        // Store, ack in first request cycle
        set_in(1'b1, 32'h0000_0008, 5'd0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("st_req", {31'b0, bus.mem_req}, 32'd1);
        chk("st_we", {31'b0, bus.mem_we}, 32'd1);
        chk("st_addr", {2'b0, bus.mem_addr}, 32'd2);
        chk("st_wdata", bus.mem_wdata, 32'hCAFE_F00D);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("st_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        chk("st_wb_wreg", {31'b0, bus.wb_wreg}, 32'd0);
        chk("st_wb_data", bus.wb_data, 32'd0);
        chk("st_req_drop", {31'b0, bus.mem_req}, 32'd0);

        // Misaligned load
        set_in(1'b1, 32'h0000_0042, 5'd3, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("mis_err", {31'b0, bus.misalign_err}, 32'd1);
        chk("mis_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        chk("mis_wb_wreg", {31'b0, bus.wb_wreg}, 32'd0);
        chk("mis_no_req", {31'b0, bus.mem_req}, 32'd0);
        chk("mis_in_ready", {31'b0, bus.in_ready}, 32'd1);
        step();
        chk("mis_err_pulse", {31'b0, bus.misalign_err}, 32'd0);
        chk("mis_still_noreq", {31'b0, bus.mem_req}, 32'd0);

        // ALU write to r0
        set_in(1'b1, 32'h0000_0099, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("r0_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        chk("r0_wb_wreg", {31'b0, bus.wb_wreg}, 32'd0);
        chk("r0_wb_data", bus.wb_data, 32'h0000_0099);

        // m2reg and wmem both set behaves as store
        set_in(1'b1, 32'h0000_0010, 5'd4, 32'h0000_55AA, 1'b1, 1'b1, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("both_we", {31'b0, bus.mem_we}, 32'd1);
        chk("both_addr", {2'b0, bus.mem_addr}, 32'd4);
        chk("both_wdata", bus.mem_wdata, 32'h0000_55AA);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_1111;
        step();
        bus.mem_ack = 1'b0;
        chk("both_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        chk("both_wb_wreg", {31'b0, bus.wb_wreg}, 32'd0);
        chk("both_wb_data", bus.wb_data, 32'd0);

        // Reset during a busy load at the top of the address space
        set_in(1'b1, 32'hFFFF_FFFC, 5'd6, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("wrap_addr", {2'b0, bus.mem_addr}, 32'h3FFF_FFFF);
        chk("rb_req", {31'b0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rb_req_off", {31'b0, bus.mem_req}, 32'd0);
        chk("rb_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rb_no_wb", {31'b0, bus.wb_valid}, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_2222;
        step();
        bus.mem_ack = 1'b0;
        chk("rb_ack_ign_wb", {31'b0, bus.wb_valid}, 32'd0);
        chk("rb_ack_ign_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rb_ack_ign_rdy", {31'b0, bus.in_ready}, 32'd1);

        // Spurious ack alongside an ALU accept
        set_in(1'b1, 32'h0000_0ABC, 5'd7, 32'h0, 1'b1, 1'b0, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_3333;
        step();
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        chk("sp_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        chk("sp_wb_data", bus.wb_data, 32'h0000_0ABC);
        chk("sp_wb_rw", {27'b0, bus.wb_rw}, 32'd7);
        chk("sp_no_req", {31'b0, bus.mem_req}, 32'd0);
        step();
        chk("sp_quiet", {31'b0, bus.wb_valid}, 32'd0);
        chk("sp_in_ready", {31'b0, bus.in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Stage 4 (MEM) of the 5-level MIPS pipeline, directly downstream of stage_ex.
- Registers EX results (ALU answer, destination register, store data) and performs word loads/stores over a simple request/acknowledge data-memory bus with variable latency.
- Drives the WB-stage inputs and back-pressures EX while a memory access is outstanding.
- Non-memory instructions pass through with fixed 1-cycle latency.

Parameters:
- ADDR_W, 30, width of word-address bus (byte address bits [ADDR_W+1:2] are used).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  EX presents a valid instruction
- in_ready  output  1  MEM can accept this cycle; EX must stall when low
- ans_ex  input  32  ALU result / effective byte address (already includes jal pc4+4 selection)
- rw_ex  input  5  destination register number
- b_ex  input  32  store data
- wreg_ex  input  1  instruction writes a register
- m2reg_ex  input  1  load: result comes from memory
- wmem_ex  input  1  store
- mem_req  output  1  bus request
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_W  word address = ans[ADDR_W+1:2]
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data, valid when mem_ack high
- mem_ack  input  1  bus completion, one-cycle pulse
- wb_valid  output  1  WB inputs valid this cycle (one-cycle pulse)
- wb_wreg  output  1  WB writes register file
- wb_rw  output  5  destination register
- wb_data  output  32  write-back value
- misalign_err  output  1  one-cycle pulse: load/store with ans_ex[1:0] != 0

Behaviour:
- Reset: all outputs 0 except in_ready = 1; FSM to IDLE; captured-instruction registers cleared.
- FSM states: IDLE, BUSY.
- in_ready = (state == IDLE); this is a combinational function of state only.
- Accept occurs when in_valid && in_ready at the rising edge. All inputs are captured.
- ALU instruction (m2reg=0, wmem=0), accepted at edge N:
  - At N+1: wb_valid=1, wb_data=ans_ex, wb_rw=rw_ex, wb_wreg=wreg_ex && (rw_ex != 0).
  - State remains IDLE, so back-to-back accepts give one result per cycle.
- Memory instruction with ans_ex[1:0]==0, accepted at edge N:
  - Go to BUSY. From N+1, mem_req=1, mem_we=wmem, mem_addr and mem_wdata are registered.
  - All bus outputs stay stable until mem_ack is sampled high. The earliest ack is sampled at edge N+2 (the first cycle req is high).
  - At the ack edge: mem_req drops, state returns to IDLE, wb_valid=1 for the next cycle.
  - Load: wb_data=mem_rdata captured at the ack edge; wb_wreg=wreg && rw != 0.
  - Store: wb_wreg=0 and wb_data=0.
  - Minimum load-use latency is accept + 2 cycles. in_ready is low during BUSY.
- Misaligned memory instruction:
  - No bus request is issued; state stays IDLE.
  - At N+1: misalign_err=1, wb_valid=1, wb_wreg=0.
- Both m2reg and wmem set: treated as a store (wmem dominates).
- When not pulsing, wb_valid=0, wb_wreg=0, misalign_err=0; wb_data and wb_rw hold their last value.
- mem_ack in IDLE (spurious or late) is ignored with no state change.
- rst during BUSY: next edge forces IDLE and mem_req=0. No wb_valid is issued for the aborted access, and a following ack is ignored.
- in_valid while BUSY: not accepted; EX must hold its inputs (no loss, no duplication).
- Address wrap: mem_addr is a plain truncation of ans_ex with no carry or range check.

Test Plan:
- ALU passthrough: accept ans=32'h0000_1234, rw=5, wreg=1 on 3 consecutive cycles (each with a different ans) → 3 consecutive wb_valid pulses, each with the matching wb_data, wb_rw=5, wb_wreg=1; in_ready stays 1.
- Load with 3-cycle ack: ans=32'h0000_0040, m2reg=1, rw=8; bus acks on the 3rd req cycle with rdata=32'hDEAD_BEEF.
  - mem_addr=30'h10 and mem_we=0 are held for 3 cycles; in_ready=0 throughout.
  - wb_valid one cycle after ack with wb_data=32'hDEAD_BEEF, wb_rw=8, wb_wreg=1.
  - A second in_valid presented during BUSY is accepted only after return to IDLE.
- Store with same-cycle ack: wmem=1, ans=32'h0000_0008, b=32'hCAFE_F00D.
  - One req cycle with mem_we=1, mem_addr=2, mem_wdata=32'hCAFE_F00D.
  - Then wb_valid=1, wb_wreg=0.
- Misaligned/zero-register cases:
  - Load with ans=32'h0000_0042 → misalign_err pulse, no mem_req, wb_wreg=0.
  - ALU op with rw=0, wreg=1 → wb_valid=1, wb_wreg=0.
- Reset mid-access: assert rst while BUSY, then pulse mem_ack → mem_req=0 after the reset edge, no wb_valid, in_ready=1, ack ignored.
- Spurious ack: mem_ack pulses in IDLE alongside an ALU accept → only the ALU result appears; no state change.
